// File: rtl/branch_pc_unit_if.sv
// Bus between the EX-stage decode/compare logic and the branch/PC unit.
// The master side is the pipeline that supplies decode and compare results.
// The slave side is branch_pc_unit, which returns the PC, redirect and trap status.
interface branch_pc_unit_if #(
  parameter int REG_WIDTH = 32,
  parameter int CNT_WIDTH = 16
);
  // Pipeline to unit
  logic                 pc_write;
  logic                 br_valid;
  logic                 jal;
  logic                 jalr;
  logic [2:0]           funct3;
  logic                 br_eq;
  logic                 br_lt;
  logic [REG_WIDTH-1:0] br_target;
  logic [REG_WIDTH-1:0] jalr_target;
  logic                 trap_ack;

  // Unit to pipeline
  logic                 br_un;
  logic [REG_WIDTH-1:0] pc;
  logic [REG_WIDTH-1:0] pc_plus4;
  logic                 taken;
  logic                 flush;
  logic                 misalign;
  logic [REG_WIDTH-1:0] trap_pc;
  logic                 illegal_br;
  logic [CNT_WIDTH-1:0] branch_cnt;
  logic [CNT_WIDTH-1:0] taken_cnt;

  modport master (
    output pc_write, br_valid, jal, jalr, funct3, br_eq, br_lt,
           br_target, jalr_target, trap_ack,
    input  br_un, pc, pc_plus4, taken, flush, misalign, trap_pc,
           illegal_br, branch_cnt, taken_cnt
  );

  modport slave (
    input  pc_write, br_valid, jal, jalr, funct3, br_eq, br_lt,
           br_target, jalr_target, trap_ack,
    output br_un, pc, pc_plus4, taken, flush, misalign, trap_pc,
           illegal_br, branch_cnt, taken_cnt
  );
endinterface

// File: rtl/branch_pc_unit.sv
// Branch resolution and PC ownership for the EX stage.
// Decides taken/not-taken from branch_comp flags and jump decode, redirects the PC,
// holds a multi-cycle flush after each redirect, and traps on misaligned targets.
module branch_pc_unit #(
  parameter int                  REG_WIDTH    = 32,
  parameter logic [REG_WIDTH-1:0] RESET_PC     = 32'h0000_0000,
  parameter logic [REG_WIDTH-1:0] TRAP_VEC     = 32'h0000_0100,
  parameter int                  FLUSH_CYCLES = 2,
  parameter int                  CNT_WIDTH    = 16
) (
  input logic             clk,
  input logic             rst_n,
  branch_pc_unit_if.slave bus
);

  localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    TRAP  = 2'd2
  } state_t;

  state_t               state;
  logic [FCW-1:0]       flush_cnt;
  logic [REG_WIDTH-1:0] pc_q;
  logic                 cond;
  logic                 illegal;
  logic [REG_WIDTH-1:0] target;
  logic                 target_misaligned;
  logic                 take;

  // Branch condition decode; reserved funct3 codes never take and flag illegal
  always_comb begin
    cond    = 1'b0;
    illegal = 1'b0;
    case (bus.funct3)
      3'b000:          cond = bus.br_eq;
      3'b001:          cond = ~bus.br_eq;
      3'b100, 3'b110:  cond = bus.br_lt;
      3'b101, 3'b111:  cond = ~bus.br_lt;
      default:         illegal = 1'b1;
    endcase
  end

  // Redirect decision and target selection; jalr outranks jal, which outranks branches
  always_comb begin
    target            = bus.jalr ? (bus.jalr_target & ~REG_WIDTH'(1)) : bus.br_target;
    target_misaligned = (target[1:0] != 2'b00);
    take              = bus.pc_write && (state == RUN) &&
                        (bus.jalr || bus.jal || (bus.br_valid && cond));
  end

  assign bus.br_un      = bus.funct3[1];
  assign bus.illegal_br = bus.br_valid & illegal;
  assign bus.taken      = take;
  assign bus.pc         = pc_q;
  assign bus.pc_plus4   = pc_q + REG_WIDTH'(4);

  // PC, redirect/trap state machine and retired-branch statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= RUN;
      pc_q           <= RESET_PC;
      flush_cnt      <= '0;
      bus.flush      <= 1'b0;
      bus.misalign   <= 1'b0;
      bus.trap_pc    <= '0;
      bus.branch_cnt <= '0;
      bus.taken_cnt  <= '0;
    end else begin
      case (state)
        RUN: begin
          if (bus.pc_write) begin
            if (bus.br_valid && !illegal) begin
              if (bus.branch_cnt != '1)
                bus.branch_cnt <= bus.branch_cnt + CNT_WIDTH'(1);
              if (cond && (bus.taken_cnt != '1))
                bus.taken_cnt <= bus.taken_cnt + CNT_WIDTH'(1);
            end
            if (take && target_misaligned) begin
              pc_q         <= TRAP_VEC;
              bus.trap_pc  <= target;
              bus.misalign <= 1'b1;
              bus.flush    <= 1'b1;
              state        <= TRAP;
            end else if (take) begin
              pc_q      <= target;
              bus.flush <= 1'b1;
              flush_cnt <= FCW'(FLUSH_CYCLES - 1);
              state     <= FLUSH;
            end else begin
              pc_q <= bus.pc_plus4;
            end
          end
        end
        FLUSH: begin
          if (bus.pc_write) begin
            pc_q <= bus.pc_plus4;
            if (flush_cnt != '0)
              flush_cnt <= flush_cnt - FCW'(1);
          end
          if (flush_cnt == '0) begin
            bus.flush <= 1'b0;
            state     <= RUN;
          end
        end
        TRAP: begin
          if (bus.trap_ack) begin
            bus.misalign <= 1'b0;
            bus.flush    <= 1'b0;
            state        <= RUN;
          end
        end
        default: begin
          state     <= RUN;
          bus.flush <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed self-checking bench for branch_pc_unit with hand-computed expectations.
module tb_branch_pc_unit;

  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   total_cnt;

  branch_pc_unit_if #(.REG_WIDTH(32), .CNT_WIDTH(16)) bus ();

  branch_pc_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive all pipeline inputs to a quiet state with the given pc_write
  task automatic idle(input logic wr);
    bus.pc_write    = wr;
    bus.br_valid    = 1'b0;
    bus.jal         = 1'b0;
    bus.jalr        = 1'b0;
    bus.funct3      = 3'b000;
    bus.br_eq       = 1'b0;
    bus.br_lt       = 1'b0;
    bus.br_target   = 32'h0;
    bus.jalr_target = 32'h0;
    bus.trap_ack    = 1'b0;
  endtask

  task automatic test_reset();
    idle(1'b0);
    rst_n = 1'b0;
    #1;
    total_cnt++; if (bus.pc !== 32'h0) $display("[TB] FAIL reset_pc: got %h expected %h", bus.pc, 32'h0); else pass_cnt++;
    total_cnt++; if (bus.flush !== 1'b0) $display("[TB] FAIL reset_flush: got %b expected 0", bus.flush); else pass_cnt++;
    total_cnt++; if (bus.misalign !== 1'b0) $display("[TB] FAIL reset_misalign: got %b expected 0", bus.misalign); else pass_cnt++;
    total_cnt++; if (bus.trap_pc !== 32'h0) $display("[TB] FAIL reset_trap_pc: got %h expected 0", bus.trap_pc); else pass_cnt++;
    total_cnt++; if (bus.branch_cnt !== 16'h0) $display("[TB] FAIL reset_branch_cnt: got %h expected 0", bus.branch_cnt); else pass_cnt++;
    total_cnt++; if (bus.taken_cnt !== 16'h0) $display("[TB] FAIL reset_taken_cnt: got %h expected 0", bus.taken_cnt); else pass_cnt++;
    total_cnt++; if (bus.pc_plus4 !== 32'h4) $display("[TB] FAIL reset_pc_plus4: got %h expected 4", bus.pc_plus4); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    total_cnt++; if (bus.pc !== 32'h0) $display("[TB] FAIL idle_hold_pc: got %h expected 0", bus.pc); else pass_cnt++;
  endtask

  task automatic test_beq_taken();
    idle(1'b1);
    bus.br_valid  = 1'b1;
    bus.funct3    = 3'b000;
    bus.br_eq     = 1'b1;
    bus.br_target = 32'h40;
    #1;
    total_cnt++; if (bus.taken !== 1'b1) $display("[TB] FAIL beq_taken: got %b expected 1", bus.taken); else pass_cnt++;
    total_cnt++; if (bus.br_un !== 1'b0) $display("[TB] FAIL beq_br_un: got %b expected 0", bus.br_un); else pass_cnt++;
    tick();
    total_cnt++; if (bus.pc !== 32'h40) $display("[TB] FAIL beq_pc: got %h expected 40", bus.pc); else pass_cnt++;
    total_cnt++; if (bus.flush !== 1'b1) $display("[TB] FAIL beq_flush1: got %b expected 1", bus.flush); else pass_cnt++;
    total_cnt++; if (bus.branch_cnt !== 16'd1) $display("[TB] FAIL beq_branch_cnt: got %0d expected 1", bus.branch_cnt); else pass_cnt++;
    total_cnt++; if (bus.taken_cnt !== 16'd1) $display("[TB] FAIL beq_taken_cnt: got %0d expected 1", bus.taken_cnt); else pass_cnt++;
    idle(1'b1);
    tick();
    total_cnt++; if (bus.flush !== 1'b1) $display("[TB] FAIL beq_flush2: got %b expected 1", bus.flush); else pass_cnt++;
    total_cnt++; if (bus.pc !== 32'h44) $display("[TB] FAIL beq_flush_pc: got %h expected 44", bus.pc); else pass_cnt++;
    tick();
    total_cnt++; if (bus.flush !== 1'b0) $display("[TB] FAIL beq_flush_drop: got %b expected 0", bus.flush); else pass_cnt++;
    total_cnt++; if (bus.pc !== 32'h48) $display("[TB] FAIL beq_after_pc: got %h expected 48", bus.pc); else pass_cnt++;
  endtask

  task automatic test_unsigned_and_not_taken();
    // BGEU 0xFFFF_FFFF vs 1: unsigned compare gives br_lt=0, so taken
    idle(1'b1);
    bus.br_valid  = 1'b1;
    bus.funct3    = 3'b111;
    bus.br_target = 32'h80;
    #1;
    total_cnt++; if (bus.br_un !== 1'b1) $display("[TB] FAIL bgeu_br_un: got %b expected 1", bus.br_un); else pass_cnt++;
    total_cnt++; if (bus.taken !== 1'b1) $display("[TB] FAIL bgeu_taken: got %b expected 1", bus.taken); else pass_cnt++;
    tick();
    total_cnt++; if (bus.pc !== 32'h80) $display("[TB] FAIL bgeu_pc: got %h expected 80", bus.pc); else pass_cnt++;
    idle(1'b1);
    tick();
    tick();
    total_cnt++; if (bus.pc !== 32'h88) $display("[TB] FAIL bgeu_after_pc: got %h expected 88", bus.pc); else pass_cnt++;
    // BLT with br_lt=0 falls through to pc+4
    bus.br_valid  = 1'b1;
    bus.funct3    = 3'b100;
    bus.br_target = 32'h200;
    #1;
    total_cnt++; if (bus.br_un !== 1'b0) $display("[TB] FAIL blt_br_un: got %b expected 0", bus.br_un); else pass_cnt++;
    total_cnt++; if (bus.taken !== 1'b0) $display("[TB] FAIL blt_taken: got %b expected 0", bus.taken); else pass_cnt++;
    tick();
    total_cnt++; if (bus.pc !== 32'h8C) $display("[TB] FAIL blt_pc: got %h expected 8c", bus.pc); else pass_cnt++;
    total_cnt++; if (bus.flush !== 1'b0) $display("[TB] FAIL blt_flush: got %b expected 0", bus.flush); else pass_cnt++;
    total_cnt++; if (bus.branch_cnt !== 16'd3) $display("[TB] FAIL blt_branch_cnt: got %0d expected 3", bus.branch_cnt); else pass_cnt++;
    total_cnt++; if (bus.taken_cnt !== 16'd2) $display("[TB] FAIL blt_taken_cnt: got %0d expected 2", bus.taken_cnt); else pass_cnt++;
    // Reserved funct3 010: illegal, never taken, not counted
    bus.funct3 = 3'b010;
    bus.br_eq  = 1'b1;
    #1;
    total_cnt++; if (bus.illegal_br !== 1'b1) $display("[TB] FAIL illegal_flag: got %b expected 1", bus.illegal_br); else pass_cnt++;
    total_cnt++; if (bus.taken !== 1'b0) $display("[TB] FAIL illegal_taken: got %b expected 0", bus.taken); else pass_cnt++;
    tick();
    total_cnt++; if (bus.pc !== 32'h90) $display("[TB] FAIL illegal_pc: got %h expected 90", bus.pc); else pass_cnt++;
    total_cnt++; if (bus.branch_cnt !== 16'd3) $display("[TB] FAIL illegal_branch_cnt: got %0d expected 3", bus.branch_cnt); else pass_cnt++;
    // JAL redirects without touching the branch statistics
    idle(1'b1);
    bus.jal       = 1'b1;
    bus.br_target = 32'h300;
    #1;
    total_cnt++; if (bus.illegal_br !== 1'b0) $display("[TB] FAIL jal_illegal: got %b expected 0", bus.illegal_br); else pass_cnt++;
    tick();
    total_cnt++; if (bus.pc !== 32'h300) $display("[TB] FAIL jal_pc: got %h expected 300", bus.pc); else pass_cnt++;
    total_cnt++; if (bus.branch_cnt !== 16'd3) $display("[TB] FAIL jal_branch_cnt: got %0d expected 3", bus.branch_cnt); else pass_cnt++;
    idle(1'b1);
    tick();
    tick();
    total_cnt++; if (bus.pc !== 32'h308) $display("[TB] FAIL jal_after_pc: got %h expected 308", bus.pc); else pass_cnt++;
  endtask

  task automatic test_jalr_trap();
    // jalr outranks a simultaneous jal; 0x103 masks to 0x102, which is misaligned
    idle(1'b1);
    bus.jalr        = 1'b1;
    bus.jal         = 1'b1;
    bus.jalr_target = 32'h103;
    bus.br_target   = 32'h400;
    #1;
    total_cnt++; if (bus.taken !== 1'b1) $display("[TB] FAIL jalr_taken: got %b expected 1", bus.taken); else pass_cnt++;
    tick();
    total_cnt++; if (bus.pc !== 32'h100) $display("[TB] FAIL trap_pc_vec: got %h expected 100", bus.pc); else pass_cnt++;
    total_cnt++; if (bus.trap_pc !== 32'h102) $display("[TB] FAIL trap_pc_latch: got %h expected 102", bus.trap_pc); else pass_cnt++;
    total_cnt++; if (bus.misalign !== 1'b1) $display("[TB] FAIL trap_misalign: got %b expected 1", bus.misalign); else pass_cnt++;
    total_cnt++; if (bus.flush !== 1'b1) $display("[TB] FAIL trap_flush: got %b expected 1", bus.flush); else pass_cnt++;
    // A taken-looking branch while trapped is ignored
    idle(1'b1);
    bus.br_valid  = 1'b1;
    bus.br_eq     = 1'b1;
    bus.br_target = 32'h500;
    #1;
    total_cnt++; if (bus.taken !== 1'b0) $display("[TB] FAIL trap_ignore_taken: got %b expected 0", bus.taken); else pass_cnt++;
    tick();
    total_cnt++; if (bus.pc !== 32'h100) $display("[TB] FAIL trap_hold_pc: got %h expected 100", bus.pc); else pass_cnt++;
    total_cnt++; if (bus.misalign !== 1'b1) $display("[TB] FAIL trap_sticky: got %b expected 1", bus.misalign); else pass_cnt++;
    total_cnt++; if (bus.branch_cnt !== 16'd3) $display("[TB] FAIL trap_branch_cnt: got %0d expected 3", bus.branch_cnt); else pass_cnt++;
    idle(1'b1);
    bus.trap_ack = 1'b1;
    tick();
    total_cnt++; if (bus.misalign !== 1'b0) $display("[TB] FAIL ack_misalign: got %b expected 0", bus.misalign); else pass_cnt++;
    total_cnt++; if (bus.flush !== 1'b0) $display("[TB] FAIL ack_flush: got %b expected 0", bus.flush); else pass_cnt++;
    total_cnt++; if (bus.pc !== 32'h100) $display("[TB] FAIL ack_pc: got %h expected 100", bus.pc); else pass_cnt++;
    bus.trap_ack = 1'b0;
    tick();
    total_cnt++; if (bus.pc !== 32'h104) $display("[TB] FAIL resume_pc: got %h expected 104", bus.pc); else pass_cnt++;
    total_cnt++; if (bus.trap_pc !== 32'h102) $display("[TB] FAIL resume_trap_pc: got %h expected 102", bus.trap_pc); else pass_cnt++;
  endtask

  task automatic test_stall();
    idle(1'b0);
    bus.br_valid  = 1'b1;
    bus.br_eq     = 1'b1;
    bus.br_target = 32'h600;
    #1;
    total_cnt++; if (bus.taken !== 1'b0) $display("[TB] FAIL stall_taken: got %b expected 0", bus.taken); else pass_cnt++;
    tick();
    total_cnt++; if (bus.pc !== 32'h104) $display("[TB] FAIL stall_pc: got %h expected 104", bus.pc); else pass_cnt++;
    total_cnt++; if (bus.flush !== 1'b0) $display("[TB] FAIL stall_flush: got %b expected 0", bus.flush); else pass_cnt++;
    total_cnt++; if (bus.branch_cnt !== 16'd3) $display("[TB] FAIL stall_branch_cnt: got %0d expected 3", bus.branch_cnt); else pass_cnt++;
    total_cnt++; if (bus.taken_cnt !== 16'd2) $display("[TB] FAIL stall_taken_cnt: got %0d expected 2", bus.taken_cnt); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    idle(1'b1);
    bus.br_valid  = 1'b1;
    bus.funct3    = 3'b001;
    bus.br_eq     = 1'b0;
    bus.br_target = 32'h700;
    tick();
    total_cnt++; if (bus.pc !== 32'h700) $display("[TB] FAIL b2b_first_pc: got %h expected 700", bus.pc); else pass_cnt++;
    total_cnt++; if (bus.taken_cnt !== 16'd3) $display("[TB] FAIL b2b_taken_cnt: got %0d expected 3", bus.taken_cnt); else pass_cnt++;
    bus.funct3    = 3'b000;
    bus.br_eq     = 1'b1;
    bus.br_target = 32'h800;
    #1;
    total_cnt++; if (bus.taken !== 1'b0) $display("[TB] FAIL b2b_second_taken: got %b expected 0", bus.taken); else pass_cnt++;
    tick();
    total_cnt++; if (bus.pc !== 32'h704) $display("[TB] FAIL b2b_second_pc: got %h expected 704", bus.pc); else pass_cnt++;
    total_cnt++; if (bus.branch_cnt !== 16'd4) $display("[TB] FAIL b2b_branch_cnt: got %0d expected 4", bus.branch_cnt); else pass_cnt++;
    idle(1'b1);
    tick();
    total_cnt++; if (bus.flush !== 1'b0) $display("[TB] FAIL b2b_flush_drop: got %b expected 0", bus.flush); else pass_cnt++;
    total_cnt++; if (bus.pc !== 32'h708) $display("[TB] FAIL b2b_after_pc: got %h expected 708", bus.pc); else pass_cnt++;
  endtask

  task automatic test_async_reset_flush();
    idle(1'b1);
    bus.br_valid  = 1'b1;
    bus.br_eq     = 1'b1;
    bus.br_target = 32'h900;
    tick();
    total_cnt++; if (bus.flush !== 1'b1) $display("[TB] FAIL areset_pre_flush: got %b expected 1", bus.flush); else pass_cnt++;
    idle(1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (bus.pc !== 32'h0) $display("[TB] FAIL areset_pc: got %h expected 0", bus.pc); else pass_cnt++;
    total_cnt++; if (bus.flush !== 1'b0) $display("[TB] FAIL areset_flush: got %b expected 0", bus.flush); else pass_cnt++;
    total_cnt++; if (bus.branch_cnt !== 16'd0) $display("[TB] FAIL areset_branch_cnt: got %0d expected 0", bus.branch_cnt); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    total_cnt++; if (bus.pc !== 32'h0) $display("[TB] FAIL areset_hold_pc: got %h expected 0", bus.pc); else pass_cnt++;
  endtask

  task automatic test_saturation();
    idle(1'b1);
    bus.br_valid = 1'b1;
    bus.funct3   = 3'b000;
    bus.br_eq    = 1'b0;
    for (int i = 0; i < 65535; i++) tick();
    total_cnt++; if (bus.branch_cnt !== 16'hFFFF) $display("[TB] FAIL sat_reach: got %h expected ffff", bus.branch_cnt); else pass_cnt++;
    total_cnt++; if (bus.pc !== 32'h3FFFC) $display("[TB] FAIL sat_pc: got %h expected 3fffc", bus.pc); else pass_cnt++;
    tick();
    total_cnt++; if (bus.branch_cnt !== 16'hFFFF) $display("[TB] FAIL sat_hold: got %h expected ffff", bus.branch_cnt); else pass_cnt++;
    total_cnt++; if (bus.taken_cnt !== 16'd0) $display("[TB] FAIL sat_taken_cnt: got %0d expected 0", bus.taken_cnt); else pass_cnt++;
    bus.br_eq     = 1'b1;
    bus.br_target = 32'h10;
    tick();
    total_cnt++; if (bus.branch_cnt !== 16'hFFFF) $display("[TB] FAIL sat_hold_taken: got %h expected ffff", bus.branch_cnt); else pass_cnt++;
    total_cnt++; if (bus.taken_cnt !== 16'd1) $display("[TB] FAIL sat_taken_inc: got %0d expected 1", bus.taken_cnt); else pass_cnt++;
    total_cnt++; if (bus.pc !== 32'h10) $display("[TB] FAIL sat_redirect_pc: got %h expected 10", bus.pc); else pass_cnt++;
  endtask

  // Scenario sequence
  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst_n     = 1'b0;
    test_reset();
    test_beq_taken();
    test_unsigned_and_not_taken();
    test_jalr_trap();
    test_stall();
    test_back_to_back();
    test_async_reset_flush();
    test_saturation();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
